timer_bank: RTL

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 12 +
 rtl/timer_chan.sv | 85 ++++++++
 rtl/timer_bank.sv | 56 +++++
 3 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: channel state encoding and default sizes.
package timer_bank_pkg;

   localparam int unsigned NCH_DEFAULT   = 4;
   localparam int unsigned WIDTH_DEFAULT = 24;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_t;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: IDLE/RUN FSM, down-counter with reload, mode bit and sticky status.
import timer_bank_pkg::*;

module timer_chan #(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             periodic,
   input  logic             enable,
   input  logic             stop,
   input  logic             clr_status,
   output logic             expired,
   output logic [WIDTH-1:0] count,
   output logic             status,
   output chan_state_t      state
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   chan_state_t      state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             status_q;
   logic             expired_q;
   logic             fire;

   // Load outranks stop and expiry; stop outranks expiry. IDLE ignores everything but load.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      fire     = 1'b0;
      if (load) begin
         state_d  = ST_RUN;
         count_d  = load_value;
         reload_d = load_value;
         mode_d   = periodic;
      end else if (state_q == ST_RUN) begin
         if (stop) begin
            state_d = ST_IDLE;
         end else if (enable) begin
            if (count_q == '0) begin
               fire = 1'b1;
               if (mode_q) begin
                  count_d = reload_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               count_d = count_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         mode_q    <= 1'b0;
         expired_q <= 1'b0;
         status_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         expired_q <= fire;
         // A new expiry beats a clear arriving in the same cycle.
         status_q  <= fire | (status_q & ~clr_status);
      end
   end

   assign expired = expired_q;
   assign count   = count_q;
   assign status  = status_q;
   assign state   = state_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent timer channels with a registered, maskable interrupt.
import timer_bank_pkg::*;

module timer_bank #(
   parameter int unsigned NCH   = NCH_DEFAULT,
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       load,
   input  logic [NCH*WIDTH-1:0] load_value,
   input  logic [NCH-1:0]       periodic,
   input  logic [NCH-1:0]       enable,
   input  logic [NCH-1:0]       stop,
   input  logic [NCH-1:0]       clr_status,
   input  logic [NCH-1:0]       irq_mask,
   output logic [NCH-1:0]       expired,
   output logic [NCH-1:0]       active,
   output logic [NCH*WIDTH-1:0] count,
   output logic [NCH-1:0]       status,
   output logic                 irq
);

   chan_state_t chan_state [NCH];
   logic        irq_q;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      timer_chan #(.WIDTH(WIDTH)) u_chan (
         .clk        (clk),
         .rst        (rst),
         .load       (load[i]),
         .load_value (load_value[i*WIDTH +: WIDTH]),
         .periodic   (periodic[i]),
         .enable     (enable[i]),
         .stop       (stop[i]),
         .clr_status (clr_status[i]),
         .expired    (expired[i]),
         .count      (count[i*WIDTH +: WIDTH]),
         .status     (status[i]),
         .state      (chan_state[i])
      );
      assign active[i] = (chan_state[i] == ST_RUN);
   end

   // irq follows the registered status, so it lags status/irq_mask by one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(status & irq_mask);
      end
   end

   assign irq = irq_q;

endmodule
